extbus_bridge: RTL and testbench
================================

// Module: extbus_bridge
// PURPOSE
//  Bridges the asynchronous 6502-style external bus (extbus_*) into the clk25 domain for the VERA register file.
//  Synchronises cs_n/phi2/rw, decodes each bus cycle, issues single-cycle register read/write strobes.
//  Drives read data back onto the pins.
//  Sits between the board top-level pins and the VERA core register decoder.
//  Supported bus: phi2 <= 4 MHz at clk25 = 25 MHz.
// PARAMETERS
//  SYNC_STAGES  2  flops per control-signal synchroniser (>=2)
// PORTS
//  clk25          in   1  system clock, 25 MHz
//  reset_n        in   1  asynchronous, active-low reset
//  extbus_cs_n    in   1  chip select, raw pin, active low
//  extbus_phi2    in   1  bus clock, raw pin
//  extbus_rw      in   1  1=read, 0=write, raw pin
//  extbus_a       in   5  register address, raw pin
//  extbus_d_in    in   8  data from pin pad
//  extbus_d_out   out  8  data to pin pad
//  extbus_d_oe    out  1  pad output enable
//  reg_addr       out  5  address of current access, stable from strobe until next cycle
//  reg_wrdata     out  8  write data, valid with reg_write
//  reg_write      out  1  1-cycle write strobe
//  reg_read       out  1  1-cycle read-start strobe
//  reg_rddata     in   8  register read data, valid 1 clk after reg_read
//  reg_read_end   out  1  1-cycle pulse at end of completed read (side effects, e.g. auto-increment)
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM in IDLE.
//   - Synchronisers are cleared with cs_n=1 and phi2=0.
//  Synchronisers:
//   - cs_n, phi2 and rw each pass through SYNC_STAGES flops; suffix _s = final stage.
//   - phi2_rise/phi2_fall are edge detects on phi2_s.
//  Capture register:
//   - a and d_in load every clk while first-stage phi2 flop = 1.
//   - Frozen while it = 0, so the capture holds the last values sampled before phi2 fell.
//  FSM (IDLE, RD, WR):
//   - IDLE -> RD on phi2_rise && !cs_n_s && rw_s.
//     - On entry: reg_read=1 for one cycle; reg_addr <= extbus_a as sampled via the capture register.
//   - IDLE -> WR on phi2_rise && !cs_n_s && !rw_s.
//   - RD:
//     - The cycle after reg_read, latch reg_rddata into extbus_d_out and set extbus_d_oe=1.
//     - Hold both until exit.
//     - Exit on phi2_fall: d_oe=0 on the same edge, reg_read_end=1 for one cycle, -> IDLE.
//   - WR exit on phi2_fall:
//     - reg_write=1 for one cycle.
//     - reg_addr/reg_wrdata take the frozen capture values.
//     - -> IDLE.
//  rw_s is sampled only at phi2_rise; later rw changes are ignored for that cycle.
//  Abort: cs_n_s=1 while in RD or WR -> IDLE next clk, d_oe=0, and no reg_write or reg_read_end.
//  phi2_rise while cs_n_s=1: no action.
//  Back-to-back bus cycles are supported:
//   - phi2_rise one clk after phi2_fall is accepted from IDLE.
//  Latency:
//   - reg_read is asserted SYNC_STAGES+1 clks after the raw phi2 rise.
//   - extbus_d_oe is asserted 2 clks after that.
//  Reset asserted mid-cycle: immediate return to reset values; a pending write is dropped.
//  extbus_d_oe is never 1 outside RD.
// STRUCTURE
//  extbus_pkg holds:
//   - FSM state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2)
//   - address width 5, data width 8
//  Sub-module sync_ff (WIDTH, STAGES, RESET_VAL):
//   - generic async-reset synchroniser chain
//   - instantiated for cs_n, phi2, rw
//  FSM, capture register and output logic live in extbus_bridge.
// TESTING
//  1. Write: cs_n=0, rw=0, a=5'h03, d=8'hA5, phi2 high 125 ns.
//     -> exactly one reg_write after phi2 fall; reg_addr=03, reg_wrdata=A5.
//  2. Read: cs_n=0, rw=1, a=5'h00, reg_rddata model=8'h5C.
//     -> one reg_read; d_oe=1 with d_out=5C before phi2 fall.
//     -> one reg_read_end after the fall; d_oe=0 after.
//  3. Abort: start a write, release cs_n mid-phi2-high.
//     -> no reg_write; FSM IDLE; d_oe stays 0.
//  4. Reset: assert reset_n=0 during RD with d_oe=1.
//     -> d_oe=0 and all strobes 0 immediately; the next normal cycle works.
//  5. Back-to-back cycles (4 MHz phi2): write a=1f/d=01, then read a=1f.
//     -> one reg_write, then one reg_read, no overlap.
//  6. Unselected: phi2 toggling with cs_n=1 for 10 cycles.
//     -> zero strobes; d_oe=0 throughout.

Source files
------------

// File: rtl/extbus_pkg.sv
// Shared widths and state encodings for the external 6502-style bus bridge.
package extbus_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // Read sub-phases: strobe issued, register data arriving, pads driven
    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_DATA  = 2'd1,
        PH_DRIVE = 2'd2
    } rd_phase_t;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser chain with asynchronous active-low reset.
// q is the final stage; q_first exposes the first flop for early qualification.
module sync_ff #(
    parameter int              WIDTH     = 1,
    parameter int              STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_first
);

    logic [STAGES-1:0][WIDTH-1:0] chain_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= {STAGES{RESET_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q       = chain_reg[STAGES-1];
    assign q_first = chain_reg[0];

endmodule

// File: rtl/extbus_bridge.sv
// Bridges the asynchronous 6502-style bus into the clk25 domain: synchronises the
// bus controls, decodes each bus cycle and issues single-cycle register strobes.
module extbus_bridge
    import extbus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk25,
    input  logic              reset_n,
    input  logic              extbus_cs_n,
    input  logic              extbus_phi2,
    input  logic              extbus_rw,
    input  logic [ADDR_W-1:0] extbus_a,
    input  logic [DATA_W-1:0] extbus_d_in,
    output logic [DATA_W-1:0] extbus_d_out,
    output logic              extbus_d_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wrdata,
    output logic              reg_write,
    output logic              reg_read,
    input  logic [DATA_W-1:0] reg_rddata,
    output logic              reg_read_end
);

    logic cs_n_s, phi2_s, rw_s;
    logic phi2_first;
    logic unused_cs_n_first, unused_rw_first;

    sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk     (clk25),
        .rst_n   (reset_n),
        .d       (extbus_cs_n),
        .q       (cs_n_s),
        .q_first (unused_cs_n_first)
    );

    sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_phi2 (
        .clk     (clk25),
        .rst_n   (reset_n),
        .d       (extbus_phi2),
        .q       (phi2_s),
        .q_first (phi2_first)
    );

    sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rw (
        .clk     (clk25),
        .rst_n   (reset_n),
        .d       (extbus_rw),
        .q       (rw_s),
        .q_first (unused_rw_first)
    );

    logic              phi2_s_d_reg;
    logic              phi2_rise, phi2_fall;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [DATA_W-1:0] cap_data_reg;
    state_t            state_reg;
    rd_phase_t         rd_phase_reg;

    assign phi2_rise = phi2_s & ~phi2_s_d_reg;
    assign phi2_fall = ~phi2_s & phi2_s_d_reg;

    // Address/data keep loading while phi2 is high, so the frozen copy holds the
    // last bus values seen before phi2 fell (covers the 6502 late write data).
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            phi2_s_d_reg <= 1'b0;
            cap_addr_reg <= '0;
            cap_data_reg <= '0;
        end else begin
            phi2_s_d_reg <= phi2_s;
            if (phi2_first) begin
                cap_addr_reg <= extbus_a;
                cap_data_reg <= extbus_d_in;
            end
        end
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            rd_phase_reg <= PH_ISSUE;
            reg_addr     <= '0;
            reg_wrdata   <= '0;
            reg_write    <= 1'b0;
            reg_read     <= 1'b0;
            reg_read_end <= 1'b0;
            extbus_d_out <= '0;
            extbus_d_oe  <= 1'b0;
        end else begin
            reg_write    <= 1'b0;
            reg_read     <= 1'b0;
            reg_read_end <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    extbus_d_oe <= 1'b0;
                    if (phi2_rise && !cs_n_s) begin
                        if (rw_s) begin
                            state_reg    <= ST_RD;
                            rd_phase_reg <= PH_ISSUE;
                            reg_read     <= 1'b1;
                            reg_addr     <= cap_addr_reg;
                        end else begin
                            state_reg <= ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (cs_n_s) begin
                        state_reg   <= ST_IDLE;
                        extbus_d_oe <= 1'b0;
                    end else if (phi2_fall) begin
                        state_reg    <= ST_IDLE;
                        extbus_d_oe  <= 1'b0;
                        reg_read_end <= 1'b1;
                    end else begin
                        case (rd_phase_reg)
                            PH_ISSUE: rd_phase_reg <= PH_DATA;
                            PH_DATA: begin
                                extbus_d_out <= reg_rddata;
                                extbus_d_oe  <= 1'b1;
                                rd_phase_reg <= PH_DRIVE;
                            end
                            default: rd_phase_reg <= PH_DRIVE;
                        endcase
                    end
                end
                ST_WR: begin
                    extbus_d_oe <= 1'b0;
                    if (cs_n_s) begin
                        state_reg <= ST_IDLE;
                    end else if (phi2_fall) begin
                        state_reg  <= ST_IDLE;
                        reg_write  <= 1'b1;
                        reg_addr   <= cap_addr_reg;
                        reg_wrdata <= cap_data_reg;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    extbus_d_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_extbus_bridge.sv
// Scoreboard bench for extbus_bridge: bus-cycle stimulus pushes expected strobes,
// a negedge monitor pops and compares them, including their cycle timing.
`timescale 1ns/1ps
module tb_extbus_bridge;

    localparam int EV_READ  = 0;
    localparam int EV_OE    = 1;
    localparam int EV_END   = 2;
    localparam int EV_WRITE = 3;

    typedef struct {
        int         kind;
        logic [4:0] addr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk25;
    logic       reset_n;
    logic       cs_n, phi2, rw;
    logic [4:0] a_pin;
    logic [7:0] d_pin;
    logic [7:0] d_out;
    logic       d_oe;
    logic [4:0] reg_addr;
    logic [7:0] reg_wrdata;
    logic       reg_write, reg_read, reg_read_end;
    logic [7:0] reg_rddata;

    int         cyc = 0;
    int         n_compared = 0;
    int         n_mismatched = 0;
    bit         mon_en = 1'b0;
    logic       d_oe_prev = 1'b0;
    ev_t        exp_q[$];
    logic [7:0] ref_regs [32];
    logic [7:0] core_regs [32];

    extbus_bridge #(.SYNC_STAGES(2)) dut (
        .clk25        (clk25),
        .reset_n      (reset_n),
        .extbus_cs_n  (cs_n),
        .extbus_phi2  (phi2),
        .extbus_rw    (rw),
        .extbus_a     (a_pin),
        .extbus_d_in  (d_pin),
        .extbus_d_out (d_out),
        .extbus_d_oe  (d_oe),
        .reg_addr     (reg_addr),
        .reg_wrdata   (reg_wrdata),
        .reg_write    (reg_write),
        .reg_read     (reg_read),
        .reg_rddata   (reg_rddata),
        .reg_read_end (reg_read_end)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'((i * 37 + 11) & 255);
        if (i == 0) v = 8'h5C;
        return v;
    endfunction

    // Register-file model standing in for the VERA core: one-clock read latency
    always @(posedge clk25) begin
        if (cyc == 0) begin
            for (int i = 0; i < 32; i++) core_regs[i] <= init_val(i);
        end else begin
            if (reg_write) core_regs[reg_addr] <= reg_wrdata;
            if (reg_read) reg_rddata <= core_regs[reg_addr];
        end
    end

    function automatic string kname(input int k);
        case (k)
            EV_READ:  return "reg_read";
            EV_OE:    return "d_oe";
            EV_END:   return "reg_read_end";
            default:  return "reg_write";
        endcase
    endfunction

    task automatic check_event(input int kind, input logic [4:0] addr, input logic [7:0] data);
        ev_t e;
        bit  bad;
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("FAIL unexpected_%s: cyc=%0d addr=%h data=%h, required no event",
                     kname(kind), cyc, addr, data);
            return;
        end
        e = exp_q.pop_front();
        bad = (e.kind != kind) || (e.cyc != cyc);
        if ((kind == EV_READ || kind == EV_WRITE) && addr !== e.addr) bad = 1'b1;
        if ((kind == EV_OE || kind == EV_WRITE) && data !== e.data) bad = 1'b1;
        if (kind == EV_END && d_oe !== 1'b0) bad = 1'b1;
        if (bad) begin
            n_mismatched++;
            $display("FAIL %s: got %s cyc=%0d addr=%h data=%h d_oe=%b, required %s cyc=%0d addr=%h data=%h",
                     kname(kind), kname(kind), cyc, addr, data, d_oe,
                     kname(e.kind), e.cyc, e.addr, e.data);
        end else begin
            $display("ok %s cyc=%0d addr=%h data=%h", kname(kind), cyc, addr, data);
        end
    endtask

    always @(negedge clk25) begin
        if (mon_en) begin
            if (reg_read) check_event(EV_READ, reg_addr, 8'h00);
            if (d_oe && !d_oe_prev) check_event(EV_OE, 5'h00, d_out);
            if (reg_read_end) check_event(EV_END, 5'h00, 8'h00);
            if (reg_write) check_event(EV_WRITE, reg_addr, reg_wrdata);
        end
        d_oe_prev <= d_oe;
    end

    task automatic push_ev(input int kind, input logic [4:0] addr, input logic [7:0] data, input int c);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // One bus cycle; phi2 edges land on clk negedges so strobe cycles are exact.
    task automatic bus_cycle(input bit is_read, input logic [4:0] a, input logic [7:0] d,
                             input int high, input int low, input bit abort);
        int rise_c;
        int fall_c;
        @(negedge clk25);
        cs_n  = 1'b0;
        rw    = is_read;
        a_pin = a;
        d_pin = is_read ? 8'($urandom) : d;
        phi2  = 1'b1;
        rise_c = cyc;
        fall_c = rise_c + high;
        if (!abort) begin
            if (is_read) begin
                push_ev(EV_READ, a, 8'h00, rise_c + 3);
                push_ev(EV_OE, 5'h00, ref_regs[a], rise_c + 5);
                push_ev(EV_END, 5'h00, 8'h00, fall_c + 3);
            end else begin
                ref_regs[a] = d;
                push_ev(EV_WRITE, a, d, fall_c + 3);
            end
        end
        for (int i = 0; i < high; i++) begin
            @(negedge clk25);
            if (abort && i == 0) cs_n = 1'b1;
        end
        phi2 = 1'b0;
        @(negedge clk25);
        a_pin = 5'($urandom);
        d_pin = 8'($urandom);
        rw    = 1'($urandom);
        @(negedge clk25);
        cs_n = 1'b1;
        repeat (low - 2) @(negedge clk25);
    endtask

    task automatic unselected_cycles(input int n);
        cs_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk25);
            phi2  = 1'b1;
            rw    = 1'($urandom);
            a_pin = 5'($urandom);
            d_pin = 8'($urandom);
            repeat (3) @(negedge clk25);
            phi2 = 1'b0;
            repeat (3) @(negedge clk25);
        end
    endtask

    task automatic reset_during_read(input logic [4:0] a);
        int  rise_c;
        bit  seen;
        logic [31:0] outs;
        @(negedge clk25);
        cs_n  = 1'b0;
        rw    = 1'b1;
        a_pin = a;
        phi2  = 1'b1;
        rise_c = cyc;
        push_ev(EV_READ, a, 8'h00, rise_c + 3);
        push_ev(EV_OE, 5'h00, ref_regs[a], rise_c + 5);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk25);
            if (d_oe) seen = 1'b1;
        end
        n_compared++;
        if (!seen) begin
            n_mismatched++;
            $display("FAIL oe_wait: d_oe=%b after 20 clks, required 1", d_oe);
        end
        @(posedge clk25);
        #5 reset_n = 1'b0;
        #1;
        outs = {d_oe, reg_read, reg_write, reg_read_end, d_out, reg_addr, reg_wrdata};
        n_compared++;
        if (outs !== 32'h0) begin
            n_mismatched++;
            $display("FAIL reset_mid: outputs=%h, required 0", outs);
        end
        phi2 = 1'b0;
        cs_n = 1'b1;
        @(negedge clk25);
        @(negedge clk25);
        reset_n = 1'b1;
        repeat (2) @(negedge clk25);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] outs;
        bit is_rd;
        for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
        reset_n = 1'b0;
        cs_n    = 1'b1;
        phi2    = 1'b0;
        rw      = 1'b1;
        a_pin   = '0;
        d_pin   = '0;
        repeat (3) @(negedge clk25);
        reset_n = 1'b1;
        @(negedge clk25);
        outs = {d_oe, reg_read, reg_write, reg_read_end, d_out, reg_addr, reg_wrdata};
        n_compared++;
        if (outs !== 32'h0) begin
            n_mismatched++;
            $display("FAIL reset_state: outputs=%h, required 0", outs);
        end
        mon_en = 1'b1;

        bus_cycle(1'b0, 5'h03, 8'hA5, 3, 5, 1'b0);
        bus_cycle(1'b1, 5'h00, 8'h00, 3, 5, 1'b0);
        bus_cycle(1'b0, 5'h07, 8'h3C, 4, 5, 1'b1);
        bus_cycle(1'b1, 5'h07, 8'h00, 3, 5, 1'b0);
        reset_during_read(5'h03);
        bus_cycle(1'b1, 5'h03, 8'h00, 3, 5, 1'b0);
        bus_cycle(1'b0, 5'h1F, 8'h01, 3, 3, 1'b0);
        bus_cycle(1'b1, 5'h1F, 8'h00, 3, 3, 1'b0);
        unselected_cycles(10);

        for (int n = 0; n < 40; n++) begin
            is_rd = 1'($urandom);
            bus_cycle(is_rd, 5'($urandom), 8'($urandom), $urandom_range(3, 5),
                      $urandom_range(3, 8), !is_rd && ($urandom_range(0, 7) == 0));
        end

        repeat (10) @(negedge clk25);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL queue_drain: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
